// File: rtl/aclk_time_entry.sv
// aclk_time_entry: push-button time/alarm entry stage feeding the alarm clock core.
//   clk, reset                 : clock, synchronous active-high reset
//   btn_sel, btn_inc, btn_set  : raw asynchronous active-high buttons
//   H_in1/H_in0/M_in1/M_in0    : BCD digits of the displayed staging value
//   LD_time, LD_alarm          : one-cycle load pulses to the core
//   edit_state                 : 0 IDLE, 1 T_HOUR, 2 T_MIN, 3 A_HOUR, 4 A_MIN
module aclk_time_entry #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_RATE     = 8,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_sel,
    input  logic       btn_inc,
    input  logic       btn_set,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic [2:0] edit_state
);
    typedef enum logic [2:0] {IDLE = 3'd0, T_HOUR = 3'd1, T_MIN = 3'd2, A_HOUR = 3'd3, A_MIN = 3'd4} state_t;
    // button index: 0 sel, 1 inc, 2 set
    logic [2:0]       s1_q, s1_d, s2_q, s2_d, db_q, db_d, dbp_q, dbp_d, arm_q, arm_d, rise;
    logic [1:0]       vld_q, vld_d;
    logic [2:0][7:0]  dbc_q, dbc_d;
    logic [15:0]      rpt_q, rpt_d;
    logic             rph_q, rph_d, rpt_fire;
    logic [31:0]      to_q, to_d;
    state_t           state_q, state_d;
    logic [4:0]       th_q, th_d, ah_q, ah_d, hh;
    logic [5:0]       tm_q, tm_d, am_q, am_d, mm;
    logic [1:0]       h1_q, h1_d;
    logic [3:0]       h0_q, h0_d, m1_q, m1_d, m0_q, m0_d;
    logic             ldt_q, ldt_d, lda_q, lda_d;
    logic             ev_set, ev_sel, ev_inc, any_ev, editing, timeout, use_alarm;

    always_comb begin
        s1_d  = {btn_set, btn_inc, btn_sel};
        s2_d  = s1_q;
        vld_d = {vld_q[0], 1'b1};
        db_d  = db_q;
        dbc_d = dbc_q;
        for (int i = 0; i < 3; i++) begin
            if (s2_q[i] != db_q[i]) begin
                if (dbc_q[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
                    db_d[i]  = ~db_q[i];
                    dbc_d[i] = 8'd0;
                end else begin
                    dbc_d[i] = dbc_q[i] + 8'd1;
                end
            end else begin
                dbc_d[i] = 8'd0;
            end
        end
        dbp_d = db_q;
        // a button only arms once it has been seen released after reset,
        // so a button held through reset produces no event
        arm_d = arm_q | ({3{vld_q[1]}} & ~s2_q & ~db_q);
        rise  = db_q & ~dbp_q & arm_q;
        // repeat counter holds cycles since the last inc event; 0 means idle
        rpt_fire = db_q[1] && arm_q[1] && (REPEAT_DELAY != 0) &&
                   (rph_q ? rpt_q == 16'(REPEAT_RATE) : rpt_q == 16'(REPEAT_DELAY));
        rpt_d = !db_q[1] ? 16'd0 : (rise[1] || rpt_fire) ? 16'd1 : (rpt_q != 16'd0) ? rpt_q + 16'd1 : 16'd0;
        rph_d = !db_q[1] ? 1'b0 : rpt_fire ? 1'b1 : rph_q;
        ev_set  = rise[2];
        ev_sel  = rise[0] && !ev_set;
        ev_inc  = (rise[1] || rpt_fire) && !rise[2] && !rise[0];
        any_ev  = |rise || rpt_fire;
        editing = state_q != IDLE;
        timeout = (TIMEOUT_CYCLES != 0) && editing && !any_ev && to_q == 32'(TIMEOUT_CYCLES - 1);
        to_d    = (any_ev || !editing || timeout) ? 32'd0 : to_q + 32'd1;
        state_d = state_q;
        th_d = th_q;
        tm_d = tm_q;
        ah_d = ah_q;
        am_d = am_q;
        ldt_d = 1'b0;
        lda_d = 1'b0;
        if (ev_set) begin
            ldt_d   = state_q == T_HOUR || state_q == T_MIN;
            lda_d   = state_q == A_HOUR || state_q == A_MIN;
            state_d = IDLE;
        end else if (ev_sel) begin
            state_d = state_q == A_MIN ? IDLE : state_t'(state_q + 3'd1);
        end else if (ev_inc) begin
            if (state_q == T_HOUR) th_d = th_q == 5'd23 ? 5'd0 : th_q + 5'd1;
            if (state_q == T_MIN)  tm_d = tm_q == 6'd59 ? 6'd0 : tm_q + 6'd1;
            if (state_q == A_HOUR) ah_d = ah_q == 5'd23 ? 5'd0 : ah_q + 5'd1;
            if (state_q == A_MIN)  am_d = am_q == 6'd59 ? 6'd0 : am_q + 6'd1;
        end else if (timeout) begin
            state_d = IDLE;
        end
        // during an alarm load the state is already IDLE, but the digits must still show the alarm
        use_alarm = lda_d || state_d == A_HOUR || state_d == A_MIN;
        hh   = use_alarm ? ah_d : th_d;
        mm   = use_alarm ? am_d : tm_d;
        h1_d = 2'(hh / 5'd10);
        h0_d = 4'(hh % 5'd10);
        m1_d = 4'(mm / 6'd10);
        m0_d = 4'(mm % 6'd10);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            db_q    <= '0;
            dbp_q   <= '0;
            arm_q   <= '0;
            vld_q   <= '0;
            dbc_q   <= '0;
            rpt_q   <= '0;
            rph_q   <= 1'b0;
            to_q    <= '0;
            state_q <= IDLE;
            th_q    <= '0;
            tm_q    <= '0;
            ah_q    <= '0;
            am_q    <= '0;
            h1_q    <= '0;
            h0_q    <= '0;
            m1_q    <= '0;
            m0_q    <= '0;
            ldt_q   <= 1'b0;
            lda_q   <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            db_q    <= db_d;
            dbp_q   <= dbp_d;
            arm_q   <= arm_d;
            vld_q   <= vld_d;
            dbc_q   <= dbc_d;
            rpt_q   <= rpt_d;
            rph_q   <= rph_d;
            to_q    <= to_d;
            state_q <= state_d;
            th_q    <= th_d;
            tm_q    <= tm_d;
            ah_q    <= ah_d;
            am_q    <= am_d;
            h1_q    <= h1_d;
            h0_q    <= h0_d;
            m1_q    <= m1_d;
            m0_q    <= m0_d;
            ldt_q   <= ldt_d;
            lda_q   <= lda_d;
        end
    end

    assign H_in1      = h1_q;
    assign H_in0      = h0_q;
    assign M_in1      = m1_q;
    assign M_in0      = m0_q;
    assign LD_time    = ldt_q;
    assign LD_alarm   = lda_q;
    assign edit_state = state_q;
endmodule

// File: tb/tb_aclk_time_entry.sv
// tb_aclk_time_entry: scoreboard bench for aclk_time_entry.
module tb_aclk_time_entry;
    localparam int RD = 16;
    localparam int RR = 8;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  btn = 3'b000;
    logic [1:0]  H_in1;
    logic [3:0]  H_in0, M_in1, M_in0;
    logic        LD_time, LD_alarm;
    logic [2:0]  edit_state;
    int          nchk = 0, nerr = 0;
    int          st = 0, th = 0, tm = 0, ah = 0, am = 0;
    logic [17:0] sb[$];
    logic        prev_ld = 1'b0;

    aclk_time_entry #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .reset(reset), .btn_sel(btn[0]), .btn_inc(btn[1]), .btn_set(btn[2]),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .edit_state(edit_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [13:0] digits(input int h, input int m);
        return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (LD_time || LD_alarm) begin
                if (sb.size() == 0) check("ld_unexpected", {LD_time, LD_alarm}, 2'b00);
                else check("ld_pulse", {LD_time, LD_alarm, H_in1, H_in0, M_in1, M_in0}, sb.pop_front());
                if (prev_ld) check("ld_consecutive", 1, 0);
            end
            prev_ld = LD_time || LD_alarm;
        end else prev_ld = 1'b0;
    end

    task automatic press(input logic [2:0] b, input int hold);
        @(posedge clk); #1;
        btn = b;
        repeat (hold) @(posedge clk);
        #1 btn = 3'b000;
        repeat (12) @(posedge clk);
    endtask

    task automatic show(input string tag);
        @(negedge clk);
        check({tag, "_state"}, edit_state, st);
        check({tag, "_digits"}, {H_in1, H_in0, M_in1, M_in0}, (st >= 3) ? digits(ah, am) : digits(th, tm));
    endtask

    task automatic sel();
        press(3'b001, 8);
        st = (st == 4) ? 0 : st + 1;
    endtask

    task automatic bump(input int n);
        case (st)
            1: th = (th + n) % 24;
            2: tm = (tm + n) % 60;
            3: ah = (ah + n) % 24;
            4: am = (am + n) % 60;
            default: ;
        endcase
    endtask

    task automatic inc(input int n);
        repeat (n) begin
            press(3'b010, 8);
            bump(1);
        end
    endtask

    task automatic set_btn(input logic [2:0] b);
        if (st == 1 || st == 2) sb.push_back({2'b10, digits(th, tm)});
        if (st == 3 || st == 4) sb.push_back({2'b01, digits(ah, am)});
        press(b, 8);
        st = 0;
    endtask

    initial begin
        int n;
        btn = 3'b111;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_state", edit_state, 0);
        check("rst_digits", {H_in1, H_in0, M_in1, M_in0}, 0);
        check("rst_ld", {LD_time, LD_alarm}, 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (30) @(posedge clk);
        show("held_after_reset");
        #1 btn = 3'b000;
        repeat (12) @(posedge clk);
        press(3'b001, 3);
        show("glitch");
        sel();
        show("t_hour");
        inc(13);
        show("hour13");
        sel();
        inc(70);
        show("min10");
        set_btn(3'b100);
        show("after_time_set");
        sel(); sel(); sel();
        show("a_hour");
        inc(25);
        show("alarm_hour");
        set_btn(3'b100);
        show("after_alarm_set");
        sel(); sel();
        n = 1;
        for (int k = RD; k < 40; k += RR) n++;
        press(3'b010, 40);
        bump(n);
        show("repeat");
        set_btn(3'b110);
        show("set_inc_same");
        sel();
        repeat (900) @(posedge clk);
        show("before_timeout");
        repeat (200) @(posedge clk);
        st = 0;
        show("timeout");
        press(3'b100, 8);
        show("set_idle");
        sel();
        inc(2);
        @(posedge clk); #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        st = 0; th = 0; tm = 0; ah = 0; am = 0;
        show("mid_edit_reset");
        #1 reset = 1'b0;
        repeat (12) @(posedge clk);
        sel();
        set_btn(3'b100);
        repeat (5) @(posedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
